multichannel_energy_monitor: RTL and testbench



---
 rtl/multichannel_energy_monitor.sv | 212 +++++++++++++++++++++
 tb/tb_multichannel_energy_monitor.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/multichannel_energy_monitor.sv
// multichannel_energy_monitor: block-averages time-multiplexed per-channel samples,
// applies a gain/shift conversion with saturation, streams results on valid/ready,
// and raises per-channel over/under alarms with hysteresis.
// Ports: clk/rst (async active-high); ena + sample_in/sample_ch/sample_valid/sample_ready
// input stream; thr_hi/thr_lo thresholds; out_data/out_ch/out_sat/out_valid/out_ready
// result stream; alarm_over/alarm_under per channel; peak_out/peak_clr peak tracker.
// Optional feature macro: ENERGY_MON_PEAK_EN (peak register; otherwise peak_out = 0).
module multichannel_energy_monitor #(
  parameter int CHANNELS = 4,
  parameter int DATA_W   = 8,
  parameter int AVG_LOG2 = 2,
  parameter int GAIN     = 3,
  parameter int SHIFT    = 1,
  parameter int HYST     = 10,
  localparam int CH_W    = $clog2(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic [DATA_W-1:0]   sample_in,
  input  logic [CH_W-1:0]     sample_ch,
  input  logic                sample_valid,
  output logic                sample_ready,
  input  logic [DATA_W-1:0]   thr_hi,
  input  logic [DATA_W-1:0]   thr_lo,
  output logic [DATA_W-1:0]   out_data,
  output logic [CH_W-1:0]     out_ch,
  output logic                out_sat,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CHANNELS-1:0] alarm_over,
  output logic [CHANNELS-1:0] alarm_under,
  output logic [DATA_W-1:0]   peak_out,
  input  logic                peak_clr
);

  localparam int ACC_W  = DATA_W + AVG_LOG2;
  localparam int CNT_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int PROD_W = DATA_W + 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  typedef enum logic [1:0] {NORMAL, OVER, UNDER} state_t;

  logic [ACC_W-1:0]  acc_q   [CHANNELS];
  logic [ACC_W-1:0]  acc_d   [CHANNELS];
  logic [CNT_W-1:0]  cnt_q   [CHANNELS];
  logic [CNT_W-1:0]  cnt_d   [CHANNELS];
  state_t            state_q [CHANNELS];
  state_t            state_d [CHANNELS];

  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [CH_W-1:0]   out_ch_q, out_ch_d;
  logic              out_sat_q, out_sat_d;
  logic              out_valid_q, out_valid_d;

  logic [CH_W:0]     ch_ext;
  logic              ch_ok;
  logic              accept;
  logic              complete;
  logic [ACC_W-1:0]  sel_acc;
  logic [CNT_W-1:0]  sel_cnt;
  logic [ACC_W-1:0]  sum;
  logic [DATA_W-1:0] avg;
  logic [PROD_W-1:0] prod;
  logic              sat;
  logic [DATA_W-1:0] res;
  logic [DATA_W:0]   r_plus_h, lo_plus_h, hi_ext, lo_ext, r_ext;

  assign sample_ready = ena & ~rst & ~(out_valid_q & ~out_ready);
  assign accept       = sample_valid & sample_ready;

  // Widen before comparing so non-power-of-two channel counts reject tags >= CHANNELS.
  assign ch_ext = {1'b0, sample_ch};
  assign ch_ok  = (ch_ext < (CH_W+1)'(CHANNELS));

  always_comb begin
    sel_acc = '0;
    sel_cnt = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (sample_ch == CH_W'(c)) begin
        sel_acc = acc_q[c];
        sel_cnt = cnt_q[c];
      end
    end
  end

  assign complete = accept & ch_ok & (sel_cnt == CNT_LAST);
  assign sum      = sel_acc + ACC_W'(sample_in);
  assign avg      = DATA_W'(sum >> AVG_LOG2);
  assign prod     = (PROD_W'(avg) * PROD_W'(GAIN)) >> SHIFT;
  assign sat      = |prod[PROD_W-1:DATA_W];
  assign res      = sat ? '1 : prod[DATA_W-1:0];

  // Hysteresis sums carry one extra bit so large thresholds never wrap.
  assign r_ext     = {1'b0, res};
  assign hi_ext    = {1'b0, thr_hi};
  assign lo_ext    = {1'b0, thr_lo};
  assign r_plus_h  = r_ext + (DATA_W+1)'(HYST);
  assign lo_plus_h = lo_ext + (DATA_W+1)'(HYST);

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      acc_d[c]   = acc_q[c];
      cnt_d[c]   = cnt_q[c];
      state_d[c] = state_q[c];
      if (accept && ch_ok && (sample_ch == CH_W'(c))) begin
        if (complete) begin
          acc_d[c] = '0;
          cnt_d[c] = '0;
        end else begin
          acc_d[c] = sum;
          cnt_d[c] = cnt_q[c] + CNT_W'(1);
        end
      end
      // From an alarm state, crossing the opposite threshold takes priority over
      // returning to NORMAL; otherwise the direct OVER<->UNDER moves could never fire.
      if (complete && (sample_ch == CH_W'(c))) begin
        case (state_q[c])
          NORMAL: begin
            if (r_ext > hi_ext)      state_d[c] = OVER;
            else if (r_ext < lo_ext) state_d[c] = UNDER;
          end
          OVER: begin
            if (r_ext < lo_ext)         state_d[c] = UNDER;
            else if (r_plus_h < hi_ext) state_d[c] = NORMAL;
          end
          UNDER: begin
            if (r_ext > hi_ext)         state_d[c] = OVER;
            else if (r_ext > lo_plus_h) state_d[c] = NORMAL;
          end
          default: state_d[c] = NORMAL;
        endcase
      end
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_sat_d   = out_sat_q;
    out_valid_d = out_valid_q;
    if (complete) begin
      out_data_d  = res;
      out_ch_d    = sample_ch;
      out_sat_d   = sat;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        acc_q[c]   <= '0;
        cnt_q[c]   <= '0;
        state_q[c] <= NORMAL;
      end
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_sat_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        acc_q[c]   <= acc_d[c];
        cnt_q[c]   <= cnt_d[c];
        state_q[c] <= state_d[c];
      end
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_sat_q   <= out_sat_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    alarm_over  = '0;
    alarm_under = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      alarm_over[c]  = (state_q[c] == OVER);
      alarm_under[c] = (state_q[c] == UNDER);
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_sat   = out_sat_q;
  assign out_valid = out_valid_q;

`ifdef ENERGY_MON_PEAK_EN
  logic [DATA_W-1:0] peak_q, peak_d;

  // A load coinciding with a clear restarts the peak at the new result.
  always_comb begin
    peak_d = peak_q;
    if (peak_clr) peak_d = '0;
    if (complete && (peak_clr || (res > peak_q))) peak_d = res;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) peak_q <= '0;
    else     peak_q <= peak_d;
  end

  assign peak_out = peak_q;
`else
  logic unused_peak_clr;
  assign unused_peak_clr = peak_clr;
  assign peak_out        = '0;
`endif

endmodule

// File: tb/tb_multichannel_energy_monitor.sv
module tb_multichannel_energy_monitor;

  localparam int N = 4;  // samples per average (2^AVG_LOG2)

  logic       clk = 1'b0;
  logic       rst;
  always #5 clk = ~clk;

  logic       ena, sample_valid, sample_ready, out_sat, out_valid, out_ready, peak_clr;
  logic [7:0] sample_in, thr_hi, thr_lo, out_data, peak_out;
  logic [1:0] sample_ch, out_ch;
  logic [3:0] alarm_over, alarm_under;

  // Second instance with a non-power-of-two channel count for out-of-range tags.
  logic       s3_valid, s3_ready, o3_sat, o3_valid;
  logic [7:0] s3_in, o3_data, p3_out;
  logic [1:0] s3_ch, o3_ch;
  logic [2:0] a3_over, a3_under;

  multichannel_energy_monitor dut (
    .clk(clk), .rst(rst), .ena(ena), .sample_in(sample_in), .sample_ch(sample_ch),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .thr_hi(thr_hi),
    .thr_lo(thr_lo), .out_data(out_data), .out_ch(out_ch), .out_sat(out_sat),
    .out_valid(out_valid), .out_ready(out_ready), .alarm_over(alarm_over),
    .alarm_under(alarm_under), .peak_out(peak_out), .peak_clr(peak_clr)
  );

  multichannel_energy_monitor #(.CHANNELS(3)) dut3 (
    .clk(clk), .rst(rst), .ena(1'b1), .sample_in(s3_in), .sample_ch(s3_ch),
    .sample_valid(s3_valid), .sample_ready(s3_ready), .thr_hi(thr_hi),
    .thr_lo(thr_lo), .out_data(o3_data), .out_ch(o3_ch), .out_sat(o3_sat),
    .out_valid(o3_valid), .out_ready(1'b1), .alarm_over(a3_over),
    .alarm_under(a3_under), .peak_out(p3_out), .peak_clr(1'b0)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: per-channel lists of pending samples, output slot, alarm flags.
  int samp_q [4][$];
  bit m_valid;
  int m_data, m_ch;
  bit m_sat;
  bit m_over [4];
  bit m_under[4];
  int m_peak;

  function automatic void model_reset();
    for (int c = 0; c < 4; c++) begin
      samp_q[c].delete();
      m_over[c]  = 0;
      m_under[c] = 0;
    end
    m_valid = 0; m_data = 0; m_ch = 0; m_sat = 0; m_peak = 0;
  endfunction

  function automatic int vec_over();
    int v = 0;
    for (int c = 0; c < 4; c++) if (m_over[c]) v |= (1 << c);
    return v;
  endfunction

  function automatic int vec_under();
    int v = 0;
    for (int c = 0; c < 4; c++) if (m_under[c]) v |= (1 << c);
    return v;
  endfunction

  // Apply one cycle of inputs, predict the edge, compare afterwards.
  task automatic step(input bit v, input int ch, input int s, input bit ordy,
                      input bit en, input bit pclr);
    bit exp_rdy, loaded;
    int sum, r, hi, lo;
    sample_valid = v; sample_ch = ch[1:0]; sample_in = s[7:0];
    out_ready = ordy; ena = en; peak_clr = pclr;
    #1;
    exp_rdy = en && !(m_valid && !ordy);
    chk("sample_ready", 32'(sample_ready), 32'(exp_rdy));
    loaded = 0;
    if (v && exp_rdy) begin
      samp_q[ch].push_back(s);
      if (samp_q[ch].size() == N) begin
        sum = 0;
        foreach (samp_q[ch][i]) sum += samp_q[ch][i];
        samp_q[ch].delete();
        r = ((sum / N) * 3) / 2;
        m_sat = (r > 255);
        if (r > 255) r = 255;
        hi = int'(thr_hi); lo = int'(thr_lo);
        if (m_over[ch]) begin
          if (r < lo) begin m_over[ch] = 0; m_under[ch] = 1; end
          else if (r + 10 < hi) m_over[ch] = 0;
        end else if (m_under[ch]) begin
          if (r > hi) begin m_under[ch] = 0; m_over[ch] = 1; end
          else if (r > lo + 10) m_under[ch] = 0;
        end else begin
          if (r > hi) m_over[ch] = 1;
          else if (r < lo) m_under[ch] = 1;
        end
        m_data = r; m_ch = ch; m_valid = 1; loaded = 1;
      end
    end
    if (!loaded && m_valid && ordy) m_valid = 0;
`ifdef ENERGY_MON_PEAK_EN
    if (loaded && (pclr || r > m_peak)) m_peak = r;
    else if (pclr) m_peak = 0;
`endif
    @(posedge clk); #1;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      chk("out_data", 32'(out_data), 32'(m_data));
      chk("out_ch", 32'(out_ch), 32'(m_ch));
      chk("out_sat", 32'(out_sat), 32'(m_sat));
    end
    chk("alarm_over", 32'(alarm_over), 32'(vec_over()));
    chk("alarm_under", 32'(alarm_under), 32'(vec_under()));
    chk("peak_out", 32'(peak_out), 32'(m_peak));
  endtask

  task automatic feed(input int ch, input int val, input int count);
    for (int i = 0; i < count; i++) step(1, ch, val, 1, 1, 0);
  endtask

  task automatic do_reset();
    rst = 1; sample_valid = 1;
    #1;
    chk("rst_ready", 32'(sample_ready), 32'd0);
    @(posedge clk); #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_sat", 32'(out_sat), 32'd0);
    chk("rst_over", 32'(alarm_over), 32'd0);
    chk("rst_under", 32'(alarm_under), 32'd0);
    chk("rst_peak", 32'(peak_out), 32'd0);
    rst = 0; sample_valid = 0;
    model_reset();
  endtask

  initial begin
    ena = 1; sample_valid = 0; sample_ch = 0; sample_in = 0; out_ready = 1; peak_clr = 0;
    thr_hi = 8'd200; thr_lo = 8'd50;
    s3_valid = 0; s3_ch = 0; s3_in = 0;
    rst = 1;
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // Out-of-range tag on the 3-channel instance: accepted, discarded, no state change.
    for (int i = 0; i < 4; i++) begin
      s3_valid = 1; s3_ch = 2'd3; s3_in = 8'd200;
      #1 chk("oor_ready", 32'(s3_ready), 32'd1);
      @(posedge clk); #1;
      chk("oor_no_out", 32'(o3_valid), 32'd0);
      chk("oor_alarm", 32'({a3_over, a3_under}), 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      s3_ch = 2'd0; s3_in = 8'd100;
      #1 chk("oor_ready", 32'(s3_ready), 32'd1);
      @(posedge clk); #1;
      chk("oor_ch0_valid", 32'(o3_valid), 32'(i == 3));
    end
    chk("oor_ch0_data", 32'(o3_data), 32'd150);
    chk("oor_ch0_ch", 32'(o3_ch), 32'd0);
    s3_valid = 0;
    @(posedge clk); #1;
    chk("oor_drain", 32'(o3_valid), 32'd0);

    // Basic conversion, alarms with hysteresis, saturation, under alarm.
    feed(0, 100, 4); step(0, 0, 0, 1, 1, 0);
    feed(1, 150, 4); feed(1, 130, 4); feed(1, 120, 4);
    feed(2, 255, 4); feed(3, 20, 4);
    // Backpressure: hold result, refuse samples, then release.
    feed(0, 100, 4);
    for (int i = 0; i < 3; i++) step(1, 1, 77, 0, 1, 0);
    step(1, 1, 77, 1, 1, 0);
    step(0, 0, 0, 1, 1, 0);
    // ena low mid-average holds the partial sum.
    feed(2, 80, 2);
    for (int i = 0; i < 3; i++) step(1, 2, 250, 1, 0, 0);
    feed(2, 80, 2);
    // Interleaved channels.
    for (int i = 0; i < 4; i++) begin step(1, 0, 100, 1, 1, 0); step(1, 3, 40, 1, 1, 0); end
    // Reset mid-average, then a fresh average and the peak clear.
    feed(0, 200, 2);
    do_reset();
    feed(0, 40, 4);
    chk("post_rst_data", 32'(out_data), 32'd60);
    step(0, 0, 0, 1, 1, 1);
    step(0, 0, 0, 1, 1, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      int s;
      if (i % 250 == 0) begin
        thr_hi = 8'($urandom_range(100, 255));
        thr_lo = 8'($urandom_range(0, 120));
      end
      s = ($urandom_range(0, 3) == 0) ? int'($urandom_range(200, 255)) : int'($urandom_range(0, 255));
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)), s,
           $urandom_range(0, 3) != 0, $urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
